inst_encoder: RTL
=================

Name: inst_encoder

Overview:
- Encodes decoded instruction fields (format, opcode, funct3/7, rd, rs1, rs2, full 32-bit immediate) into a 32-bit RV32I instruction word.
- It is the inverse of the immediate generator: field placement and range rules match exactly what that decoder extracts.
- Sits between the boot/test loader and instruction memory.
- Streams encoded words out with sequential byte addresses over a valid/ready handshake.
- Flags immediates the target format cannot represent.

Parameters:
- ADDR_W, 10, width of the byte-address counter on out_addr; wraps modulo 2^ADDR_W.
- RST_ADDR, 0, counter value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept.
- in_fmt  in  3  format code (fmt_e): R, I, I_SH, I_U, S, B, U, J.
- in_opcode  in  7  opcode placed at [6:0].
- in_funct3  in  3  placed at [14:12]; ignored for U/J.
- in_funct7  in  7  placed at [31:25] for R and I_SH only.
- in_rd  in  5  [11:7] for R/I/I_SH/I_U/U/J.
- in_rs1  in  5  [19:15] for R/I/I_SH/I_U/S/B.
- in_rs2  in  5  [24:20] for R/S/B.
- in_imm  in  32  full-width immediate value.
- base_load  in  1  load address counter.
- base_addr  in  ADDR_W  value loaded into the counter.
- err_clr  in  1  clears err_sticky.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts.
- out_inst  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_inst.
- out_err  out  1  immediate out of range for this word.
- err_sticky  out  1  set by any accepted word with an error.

Behaviour:
- Reset values: out_valid=0, out_inst=0, out_addr=0, out_err=0, err_sticky=0, counter=RST_ADDR.
- Single output register; latency 1 cycle from accept to out_valid.
- in_ready = !base_load && (!out_valid || out_ready).
  - Accept and drain may occur in the same cycle: full throughput.
- Accept = in_valid && in_ready. On accept:
  - out_inst, out_err and out_addr are loaded; out_addr takes the current counter value.
  - Counter += 4, wrapping modulo 2^ADDR_W.
- While out_valid && !out_ready: out_inst, out_addr and out_err hold stable, and the counter holds.
- Field placement:
  - I, I_U: imm[11:0] goes to [31:20].
  - I_SH: funct7 goes to [31:25], imm[4:0] goes to [24:20].
  - S: imm[11:5] goes to [31:25], imm[4:0] goes to [11:7].
  - B: imm[12] to [31], imm[10:5] to [30:25], imm[4:1] to [11:8], imm[11] to [7].
  - U: imm[31:12] goes to [31:12].
  - J: imm[20] to [31], imm[10:1] to [30:21], imm[11] to [20], imm[19:12] to [19:12].
  - R: the immediate is ignored.
- Range rules; a violation sets out_err=1:
  - I, S: signed, -2048..2047.
  - I_U: unsigned, 0..4095 (zero-extended on decode).
  - I_SH: 0..31.
  - B: signed 13-bit and imm[0]=0.
  - J: signed 21-bit and imm[0]=0.
  - U: imm[11:0]=0.
  - R: never an error.
- Out-of-range words are still emitted, with truncated bits placed per the format; they are not dropped.
- err_sticky set on accept with error. err_clr clears it; a simultaneous set wins over err_clr.
- Unknown in_fmt: out_inst=0, out_err=1.
- base_load: counter := base_addr next edge; in_ready is forced 0 that cycle. A word already held in the output register keeps its address.
- Reset mid-stream: a pending word is discarded immediately, the counter returns to RST_ADDR, and err_sticky clears.

Decomposition:
- Package inst_enc_pkg:
  - fmt_e enum.
  - Opcode constants: OP_IMM=7'b0010011, STORE=7'b0100011, BRANCH=7'b1100011, LUI=7'b0110111, JAL=7'b1101111, OP=7'b0110011.
  - Range limit constants.
- Sub-module imm_range_chk: combinational fmt + imm to err. It is shared with a future assembler checker.

Test Plan:
- ADDI x1,x0,-1 (I, f3=000, imm=0xFFFFFFFF) -> out_inst=0xFFF00093, out_err=0, out_addr=0x000.
- SW x2,8(x1) (S, f3=010) then BEQ x0,x0,-4 (B) back-to-back with out_ready=1 -> 0x0020A423 @0x000, 0xFE000EE3 @0x004, one per cycle.
- LUI x5 with imm=0x12345000 -> 0x123452B7. Repeat with imm=0x12345001 -> out_err=1 and err_sticky=1; then err_clr -> err_sticky=0.
- Range boundaries:
  - I_U imm=0xFFF -> no error; I_U imm=0xFFFFFFFF -> error.
  - I_SH imm=31 -> no error; I_SH imm=32 -> error.
  - B imm=5 -> error; J imm=-1048576 -> no error.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_inst/out_addr stable, counter unchanged; release -> next word at +4.
- base_load base_addr=0x3FC, then two words -> addresses 0x3FC and 0x000 (wrap). Assert rst mid-transfer -> out_valid=0 asynchronously, next word at 0x000.

Source files
------------

// File: rtl/inst_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder: format codes,
// opcodes and immediate range limits.
package inst_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_I_SH = 3'd2,
        FMT_I_U  = 3'd3,
        FMT_S    = 3'd4,
        FMT_B    = 3'd5,
        FMT_U    = 3'd6,
        FMT_J    = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMMU_MAX  = 4095;
    localparam int SHAMT_MAX = 31;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4095;
    localparam int IMM21_MIN = -1048576;
    localparam int IMM21_MAX = 1048575;

    // True when imm, read as two's complement, lies in [lo, hi].
    function automatic logic in_srange(input logic [31:0] imm, input int lo, input int hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Handshake bus of the encoder: decoded fields in, encoded word and address out.
interface inst_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    modport master (
        output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, out_err
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_addr, out_err
    );
endinterface

// File: rtl/imm_range_chk.sv
// Combinational check that an immediate is representable in the given format;
// also intended for reuse by the assembler-side checker.
module imm_range_chk
    import inst_enc_pkg::*;
(
    input  fmt_e        fmt_i,
    input  logic [31:0] imm_i,
    output logic        err_o
);
    always_comb begin
        err_o = 1'b1;
        case (fmt_i)
            FMT_R:          err_o = 1'b0;
            FMT_I, FMT_S:   err_o = !in_srange(imm_i, IMM12_MIN, IMM12_MAX);
            FMT_I_U:        err_o = (imm_i > 32'(IMMU_MAX));
            FMT_I_SH:       err_o = (imm_i > 32'(SHAMT_MAX));
            // Branch and jump offsets are halfword multiples; bit 0 is never encoded.
            FMT_B:          err_o = !in_srange(imm_i, IMM13_MIN, IMM13_MAX) || imm_i[0];
            FMT_J:          err_o = !in_srange(imm_i, IMM21_MIN, IMM21_MAX) || imm_i[0];
            FMT_U:          err_o = (imm_i[11:0] != 12'h000);
            default:        err_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/inst_encoder.sv
// Packs decoded RV32I fields into instruction words and streams them out with
// sequential byte addresses through a single output register.
module inst_encoder
    import inst_enc_pkg::*;
#(
    parameter int                ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] RST_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    inst_encoder_if.slave     bus,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              err_clr,
    output logic              err_sticky
);
    logic              valid_q, valid_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              sticky_q, sticky_d;

    logic        accept;
    logic [31:0] enc_word;
    logic        range_err;
    fmt_e        fmt;

    assign fmt = fmt_e'(bus.in_fmt);

    imm_range_chk u_chk (
        .fmt_i (fmt),
        .imm_i (bus.in_imm),
        .err_o (range_err)
    );

    always_comb begin
        enc_word = 32'h0;
        case (fmt)
            FMT_R:   enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                 bus.in_rd, bus.in_opcode};
            FMT_I, FMT_I_U:
                     enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                                 bus.in_rd, bus.in_opcode};
            FMT_I_SH:
                     enc_word = {bus.in_funct7, bus.in_imm[4:0], bus.in_rs1, bus.in_funct3,
                                 bus.in_rd, bus.in_opcode};
            FMT_S:   enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                 bus.in_imm[4:0], bus.in_opcode};
            FMT_B:   enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                                 bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
            FMT_U:   enc_word = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
            FMT_J:   enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                                 bus.in_imm[19:12], bus.in_rd, bus.in_opcode};
            default: enc_word = 32'h0;
        endcase
    end

    // A base load owns the counter this cycle, so no word may take an address.
    assign bus.in_ready = !base_load && (!valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        valid_d  = valid_q;
        inst_d   = inst_q;
        addr_d   = addr_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;

        if (accept) begin
            valid_d = 1'b1;
            inst_d  = enc_word;
            err_d   = range_err;
            addr_d  = cnt_q;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end

        if (base_load)
            cnt_d = base_addr;
        else if (accept)
            cnt_d = cnt_q + ADDR_W'(4);

        if (accept && range_err)
            sticky_d = 1'b1;
        else if (err_clr)
            sticky_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            inst_q   <= 32'h0;
            addr_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= RST_ADDR;
            sticky_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            inst_q   <= inst_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_inst  = inst_q;
    assign bus.out_addr  = addr_q;
    assign bus.out_err   = err_q;
    assign err_sticky    = sticky_q;
endmodule
